elevator_ctrl: RTL and testbench

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elevator_ctrl.sv | 152 +++++++++++++++
 tb/tb_elevator_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Four-floor SCAN elevator controller: latches calls, travels floor to floor on tick strobes, holds the door open.
// Optional emergency stop input is enabled by defining ELEV_ESTOP_EN.
module elevator_ctrl #(
   parameter int unsigned MOVE_TICKS = 4,
   parameter int unsigned DOOR_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [3:0] req,
`ifdef ELEV_ESTOP_EN
   input  logic       estop,
`endif
   output logic [1:0] floor,
   output logic       dir_up,
   output logic       moving,
   output logic       door_open,
   output logic [3:0] pending
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_e;

   localparam logic [7:0] MOVE_LAST = 8'(MOVE_TICKS - 1);
   localparam logic [7:0] DOOR_LAST = 8'(DOOR_TICKS - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] floor_q, floor_d;
   logic       dir_q, dir_d;
   logic [3:0] pending_q, pending_d;

   logic       halt;
   logic [3:0] hereMask;
   logic [3:0] aboveMask;
   logic [3:0] belowMask;
   logic [3:0] reqLatch;
   logic [3:0] clearMask;
   logic [1:0] stepFloor;
   logic       callsAhead;
   logic       atEnd;

`ifdef ELEV_ESTOP_EN
   assign halt = estop;
`else
   assign halt = 1'b0;
`endif

   // Floor-relative views of the call register used by the direction and latch logic.
   always_comb begin
      hereMask   = 4'b0001 << floor_q;
      aboveMask  = 4'b1110 << floor_q;
      belowMask  = ~(4'b1111 << floor_q);
      callsAhead = dir_q ? |(pending_q & aboveMask) : |(pending_q & belowMask);
      stepFloor  = dir_q ? floor_q + 2'd1 : floor_q - 2'd1;
      atEnd      = dir_q ? (floor_q == 2'd3) : (floor_q == 2'd0);
      reqLatch   = (state_q == DOOR) ? (req & ~hereMask) : req;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      floor_d   = floor_q;
      dir_d     = dir_q;
      clearMask = 4'b0000;

      if (!halt) begin
         case (state_q)
            IDLE: begin
               if (pending_q != 4'b0000) begin
                  cnt_d = 8'd0;
                  if (pending_q[floor_q]) begin
                     state_d   = DOOR;
                     clearMask = hereMask;
                  end else begin
                     state_d = MOVE;
                     if (!callsAhead) begin
                        dir_d = ~dir_q;
                     end
                  end
               end
            end

            MOVE: begin
               if (tick) begin
                  if (cnt_q == MOVE_LAST) begin
                     cnt_d = 8'd0;
                     // Direction is frozen while moving; the end-of-shaft guard is purely defensive.
                     if (atEnd) begin
                        state_d = IDLE;
                     end else begin
                        floor_d = stepFloor;
                        if (pending_q[stepFloor]) begin
                           state_d   = DOOR;
                           clearMask = 4'b0001 << stepFloor;
                        end
                     end
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end

            DOOR: begin
               if (req[floor_q]) begin
                  cnt_d = 8'd0;
               end else if (tick) begin
                  if (cnt_q == DOOR_LAST) begin
                     state_d = IDLE;
                     cnt_d   = 8'd0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end
         endcase
      end

      pending_d = (pending_q | reqLatch) & ~clearMask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         floor_q   <= 2'd0;
         dir_q     <= 1'b1;
         pending_q <= 4'b0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         floor_q   <= floor_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
      end
   end

   assign floor     = floor_q;
   assign dir_up    = dir_q;
   assign moving    = (state_q == MOVE);
   assign door_open = (state_q == DOOR);
   assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: directed scenarios plus random calls/ticks against a behavioural model.
// Define ELEV_ESTOP_EN to also exercise the emergency stop input.
module tb_elevator_ctrl;

   localparam int MOVE_TICKS = 4;
   localparam int DOOR_TICKS = 3;

   localparam int MODE_IDLE   = 0;
   localparam int MODE_TRAVEL = 1;
   localparam int MODE_DOOR   = 2;

   typedef struct packed {
      logic [1:0] floor;
      logic       dirUp;
      logic       moving;
      logic       doorOpen;
      logic [3:0] pending;
   } expT;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic [3:0] req;
`ifdef ELEV_ESTOP_EN
   logic       estopSig;
`endif
   logic [1:0] floor;
   logic       dir_up;
   logic       moving;
   logic       door_open;
   logic [3:0] pending;

   expT expQ[$];
   int  checkCount = 0;
   int  failCount  = 0;

   // Behavioural model: position, heading, elapsed ticks and a call list.
   int  mMode;
   int  mPos;
   int  mTimer;
   bit  mUp;
   bit  mCalls[4];

   elevator_ctrl #(
      .MOVE_TICKS(MOVE_TICKS),
      .DOOR_TICKS(DOOR_TICKS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tick(tick),
      .req(req),
`ifdef ELEV_ESTOP_EN
      .estop(estopSig),
`endif
      .floor(floor),
      .dir_up(dir_up),
      .moving(moving),
      .door_open(door_open),
      .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkField(input string name, input logic [7:0] got, input logic [7:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mMode  = MODE_IDLE;
      mPos   = 0;
      mTimer = 0;
      mUp    = 1'b1;
      for (int i = 0; i < 4; i++) mCalls[i] = 1'b0;
   endtask

   function automatic bit anyCall();
      bit found = 1'b0;
      for (int i = 0; i < 4; i++) if (mCalls[i]) found = 1'b1;
      return found;
   endfunction

   function automatic bit callAhead();
      bit found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (mCalls[i] && ((mUp && i > mPos) || (!mUp && i < mPos))) found = 1'b1;
      end
      return found;
   endfunction

   function automatic expT modelOutputs();
      expT e;
      e.floor    = 2'(mPos);
      e.dirUp    = mUp;
      e.moving   = (mMode == MODE_TRAVEL);
      e.doorOpen = (mMode == MODE_DOOR);
      for (int i = 0; i < 4; i++) e.pending[i] = mCalls[i];
      return e;
   endfunction

   // One clock edge of the elevator as described by its rules.
   task automatic modelStep(input logic [3:0] r, input logic t, input logic e);
      bit nextCalls[4];
      int np;
      for (int i = 0; i < 4; i++) begin
         nextCalls[i] = mCalls[i] || (r[i] && !(mMode == MODE_DOOR && i == mPos));
      end
      if (!e) begin
         case (mMode)
            MODE_IDLE: begin
               if (anyCall()) begin
                  mTimer = 0;
                  if (mCalls[mPos]) begin
                     mMode = MODE_DOOR;
                     nextCalls[mPos] = 1'b0;
                  end else begin
                     if (!callAhead()) mUp = !mUp;
                     mMode = MODE_TRAVEL;
                  end
               end
            end
            MODE_TRAVEL: begin
               if (t) begin
                  mTimer++;
                  if (mTimer == MOVE_TICKS) begin
                     mTimer = 0;
                     np = mUp ? mPos + 1 : mPos - 1;
                     mPos = np;
                     if (mCalls[np]) begin
                        mMode = MODE_DOOR;
                        nextCalls[np] = 1'b0;
                     end
                  end
               end
            end
            default: begin
               if (r[mPos]) begin
                  mTimer = 0;
               end else if (t) begin
                  mTimer++;
                  if (mTimer == DOOR_TICKS) begin
                     mTimer = 0;
                     mMode  = MODE_IDLE;
                  end
               end
            end
         endcase
      end
      for (int i = 0; i < 4; i++) mCalls[i] = nextCalls[i];
   endtask

   // Drive one cycle of inputs, advance the model and queue what the DUT must show after the edge.
   task automatic applyStimulus(input logic [3:0] r, input logic t, input logic e, input logic rn);
      @(negedge clk);
      req   = r;
      tick  = t;
      rst_n = rn;
`ifdef ELEV_ESTOP_EN
      estopSig = e;
`endif
      if (!rn) begin
         modelReset();
         #1;
         checkField("async_reset_floor", 8'(floor), 8'd0);
         checkField("async_reset_pending", 8'(pending), 8'd0);
         checkField("async_reset_moving", 8'(moving), 8'd0);
         checkField("async_reset_door", 8'(door_open), 8'd0);
      end else begin
         modelStep(r, t, e);
      end
      expQ.push_back(modelOutputs());
   endtask

   task automatic resetDut();
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic runTicks(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
   endtask

   // Monitor: every edge the DUT presents a fresh output set, compared against the oldest expectation.
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkField("floor", 8'(floor), 8'(e.floor));
            checkField("dir_up", 8'(dir_up), 8'(e.dirUp));
            checkField("moving", 8'(moving), 8'(e.moving));
            checkField("door_open", 8'(door_open), 8'(e.doorOpen));
            checkField("pending", 8'(pending), 8'(e.pending));
         end
      end
   end

   initial begin
      logic [3:0] r;
      logic       t;
      logic       es;
      int         guard;

      rst_n = 1'b0;
      req   = 4'b0000;
      tick  = 1'b0;
`ifdef ELEV_ESTOP_EN
      estopSig = 1'b0;
`endif
      modelReset();

      // Call at the current floor: door opens, times out, returns to idle.
      resetDut();
      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
      runTicks(8);

      // Top-floor call from the ground floor.
      resetDut();
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      runTicks(18);

      // Call behind the car while travelling up.
      resetDut();
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
      runTicks(6);
      applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
      runTicks(40);

      // Door reopen at floor 2.
      resetDut();
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while (mMode != MODE_DOOR && guard < 50) begin
         runTicks(1);
         guard++;
      end
      runTicks(1);
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
      runTicks(6);

      // Reset while moving past floor 2.
      resetDut();
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while (!(mMode == MODE_TRAVEL && mPos == 2) && guard < 50) begin
         runTicks(1);
         guard++;
      end
      runTicks(1);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
      runTicks(3);

`ifdef ELEV_ESTOP_EN
      // Emergency stop mid-travel with two ticks already counted.
      resetDut();
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while (!(mMode == MODE_TRAVEL && mTimer == 2) && guard < 50) begin
         runTicks(1);
         guard++;
      end
      for (int i = 0; i < 10; i++) applyStimulus(4'b0010, 1'b1, 1'b1, 1'b1);
      runTicks(4);
`endif

      // Random traffic.
      resetDut();
      es = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         t = 1'($urandom_range(0, 1));
`ifdef ELEV_ESTOP_EN
         if ($urandom_range(0, 40) == 0) es = ~es;
`endif
         if ($urandom_range(0, 600) == 0) begin
            applyStimulus(r, t, es, 1'b0);
         end else begin
            applyStimulus(r, t, es, 1'b1);
         end
      end

      @(posedge clk);
      #2;
      checkField("scoreboard_drained", 8'(expQ.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
